// File: rtl/apb_requester.sv
// apb_requester: turns single commands (i_req/i_wr/i_addr/i_wdata) into APB
// transfers with a SETUP cycle followed by an ACCESS phase. It accepts one
// command at a time and pulses o_done one cycle after the transfer completes.
//
// Handshake: a command is taken on a rising PCLK edge where i_req=1 and
// o_ready=1. o_ready is high only in IDLE, and i_req is ignored otherwise
// (nothing is queued). o_done/o_err pulse for exactly one cycle per completion.
//
// Optional build macro: APB_TIMEOUT_EN. When it is defined, an ACCESS phase
// with PREADY low for TIMEOUT_CYCLES consecutive cycles is abandoned and
// completes with o_err=1. When it is undefined, ACCESS waits forever and
// o_err is tied low. The port list is the same in both builds.
//
// The current FSM state is the internal signal 'state'.
module apb_requester #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // One-hot state encoding; any other value is illegal and recovers to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } state_t;

  state_t state;

  // Elaboration-time sanity check on the timeout length.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The count equals LIMIT during the TIMEOUT_CYCLES-th wait cycle.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
`else
  // Without the timeout feature, a completion is never an error.
  assign o_err = 1'b0;
`endif

  // FSM with all outputs registered; reset aborts any transfer silently.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      o_ready <= 1'b1;
      o_done  <= 1'b0;
      o_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      o_err   <= 1'b0;
      tmo_cnt <= '0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef APB_TIMEOUT_EN
      o_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_req && o_ready) begin
            state   <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            o_ready <= 1'b0;
            PWRITE  <= i_wr;
            PADDR   <= i_addr;
            PWDATA  <= i_wdata;
          end
        end
        SETUP: begin
          // PREADY is deliberately not looked at here.
          state   <= ACCESS;
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            // Normal completion wins even when the timeout is due this cycle.
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            o_ready <= 1'b1;
            o_done  <= 1'b1;
            if (!PWRITE) begin
              o_rdata <= PRDATA;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt == LIMIT) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            o_ready <= 1'b1;
            o_done  <= 1'b1;
            o_err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Testbench for apb_requester: directed scenarios plus randomized commands,
// checked against a transaction-level model of the expected APB timing.
module tb_apb_requester;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK;
  logic          PRESET;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          i_req, i_wr;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic          o_ready, o_done, o_err;
  logic [DW-1:0] o_rdata;

  int vectors;
  int miscompares;

  // Reference state: the last read data that completed without error.
  logic [DW-1:0] exp_rdata;

  apb_requester #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PREADY(PREADY),
    .PRDATA(PRDATA),
    .i_req(i_req),
    .i_wr(i_wr),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_ready(o_ready),
    .o_done(o_done),
    .o_err(o_err),
    .o_rdata(o_rdata)
  );

  // Clock: 10 ns period.
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One command from acceptance to the cycle after completion.
  // waits = number of PREADY-low ACCESS cycles before PREADY rises.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int waits,
                         input logic [DW-1:0] rd);
    int n_acc;
    logic exp_err;
    exp_err = TO_EN && (waits >= TO);
    n_acc   = exp_err ? TO : waits + 1;

    check("ready_before_accept", o_ready, 1'b1);
    i_req   = 1'b1;
    i_wr    = wr;
    i_addr  = addr;
    i_wdata = wdata;
    PREADY  = 1'($urandom_range(0, 1));
    step();
    // Command inputs and PREADY must be ignored from here on.
    i_req   = 1'($urandom_range(0, 1));
    i_wr    = ~wr;
    i_addr  = AW'($urandom);
    i_wdata = DW'($urandom);
    PREADY  = 1'($urandom_range(0, 1));
    check("setup_psel", PSEL, 1'b1);
    check("setup_penable", PENABLE, 1'b0);
    check("setup_ready", o_ready, 1'b0);
    check("setup_done", o_done, 1'b0);
    check("setup_pwrite", PWRITE, wr);
    check("setup_paddr", PADDR, addr);
    check("setup_pwdata", PWDATA, wdata);
    step();
    for (int i = 0; i < n_acc; i++) begin
      PREADY = (i == waits);
      PRDATA = (i == waits) ? rd : DW'($urandom);
      check("access_psel", PSEL, 1'b1);
      check("access_penable", PENABLE, 1'b1);
      check("access_done", o_done, 1'b0);
      check("access_ready", o_ready, 1'b0);
      check("access_paddr", PADDR, addr);
      check("access_pwdata", PWDATA, wdata);
      check("access_pwrite", PWRITE, wr);
      step();
    end
    if (!wr && !exp_err) exp_rdata = rd;
    i_req  = 1'b0;
    PREADY = 1'($urandom_range(0, 1));
    check("done_pulse", o_done, 1'b1);
    check("done_err", o_err, exp_err);
    check("done_psel", PSEL, 1'b0);
    check("done_penable", PENABLE, 1'b0);
    check("done_ready", o_ready, 1'b1);
    check("done_rdata", o_rdata, exp_rdata);
    check("idle_paddr_held", PADDR, addr);
    step();
    check("after_done", o_done, 1'b0);
    check("after_err", o_err, 1'b0);
    check("after_psel", PSEL, 1'b0);
    check("after_ready", o_ready, 1'b1);
    check("after_rdata", o_rdata, exp_rdata);
  endtask

  // i_req held high with PREADY=1: one acceptance every 3 cycles.
  task automatic run_back_to_back(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] r;
    logic          w;
    a = '0; d = '0; r = '0; w = 1'b0;
    i_req  = 1'b1;
    PREADY = 1'b1;
    for (int c = 0; c < 3 * n; c++) begin
      if (c % 3 == 0) begin
        a = AW'($urandom); d = DW'($urandom); w = 1'($urandom_range(0, 1));
        i_addr = a; i_wdata = d; i_wr = w;
      end else begin
        i_addr = AW'($urandom); i_wdata = DW'($urandom); i_wr = 1'($urandom_range(0, 1));
      end
      if (c % 3 == 2) begin
        r = DW'($urandom);
        PRDATA = r;
        if (!w) exp_rdata = r;
      end
      step();
      case (c % 3)
        0: begin
          check("b2b_setup_psel", PSEL, 1'b1);
          check("b2b_setup_penable", PENABLE, 1'b0);
          check("b2b_setup_ready", o_ready, 1'b0);
          check("b2b_paddr", PADDR, a);
          check("b2b_pwdata", PWDATA, d);
          check("b2b_pwrite", PWRITE, w);
        end
        1: begin
          check("b2b_access_psel", PSEL, 1'b1);
          check("b2b_access_penable", PENABLE, 1'b1);
          check("b2b_access_done", o_done, 1'b0);
        end
        default: begin
          check("b2b_idle_psel", PSEL, 1'b0);
          check("b2b_idle_done", o_done, 1'b1);
          check("b2b_idle_err", o_err, 1'b0);
          check("b2b_idle_ready", o_ready, 1'b1);
          check("b2b_rdata", o_rdata, exp_rdata);
        end
      endcase
    end
    i_req = 1'b0;
    step();
    check("b2b_tail_done", o_done, 1'b0);
    check("b2b_tail_psel", PSEL, 1'b0);
  endtask

  // Bound on total run time in case the stimulus ever stalls.
  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_rdata   = '0;
    PRESET  = 1'b1;
    PREADY  = 1'b0;
    PRDATA  = '0;
    i_req   = 1'b0;
    i_wr    = 1'b0;
    i_addr  = '0;
    i_wdata = '0;

    // Reset values.
    repeat (2) step();
    check("rst_psel", PSEL, 1'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_paddr", PADDR, '0);
    check("rst_pwdata", PWDATA, '0);
    check("rst_ready", o_ready, 1'b1);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_rdata", o_rdata, '0);
    PRESET = 1'b0;

    // Write with PREADY high immediately.
    run_txn(1'b1, 16'h0004, 16'hA5A5, 0, 16'h0000);
    // Read with 3 wait states.
    run_txn(1'b0, 16'h0010, 16'h0000, 3, 16'h1234);
    // Write must leave o_rdata alone.
    run_txn(1'b1, 16'h0020, 16'h5A5A, 2, 16'hFFFF);

    // Continuous i_req.
    run_back_to_back(4);

    // Long wait: timeout when enabled, otherwise 100 cycles with no completion.
    run_txn(1'b0, 16'h0030, 16'h0000, 100, 16'hBEEF);
    // PREADY rises exactly when the timeout count would be reached.
    run_txn(1'b0, 16'h0040, 16'h0000, TO - 1, 16'hC0DE);
    // Over-long write wait.
    run_txn(1'b1, 16'h0050, 16'h7777, TO + 3, 16'h0000);

    // Randomized commands.
    for (int k = 0; k < 24; k++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                      : int'($urandom_range(0, 5));
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), w, DW'($urandom));
    end

    // Reset during ACCESS aborts the transfer with no completion.
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0099; i_wdata = 16'h0000; PREADY = 1'b0;
    step();
    i_req = 1'b0;
    step();
    check("pre_rst_penable", PENABLE, 1'b1);
    #2;
    PRESET = 1'b1;
    #1;
    exp_rdata = '0;
    check("mid_rst_psel", PSEL, 1'b0);
    check("mid_rst_penable", PENABLE, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    check("mid_rst_done", o_done, 1'b0);
    check("mid_rst_rdata", o_rdata, exp_rdata);
    check("mid_rst_paddr", PADDR, '0);
    PREADY = 1'b1;
    step();
    check("held_rst_done", o_done, 1'b0);
    PRESET = 1'b0;
    // First edge after reset release accepts a command.
    run_txn(1'b0, 16'h00AA, 16'h0000, 1, 16'h4321);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the width of PADDR and i_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the width of PWDATA, PRDATA, i_wdata and o_rdata.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the ACCESS-phase wait limit used when APB_TIMEOUT_EN is defined.
REQ-004 SHALL have PCLK, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have PRESET, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 SHALL have PSEL, PENABLE and PWRITE, each output, 1 bit: the APB requester controls.
REQ-007 SHALL have PADDR, output, ADDR_WIDTH bits, and PWDATA, output, DATA_WIDTH bits.
REQ-008 SHALL have PREADY, input, 1 bit, and PRDATA, input, DATA_WIDTH bits.
REQ-009 SHALL have i_req, input, 1 bit: command request.
REQ-010 SHALL have i_wr, input, 1 bit: command direction, 1 = write, 0 = read.
REQ-011 SHALL have i_addr, input, ADDR_WIDTH bits, and i_wdata, input, DATA_WIDTH bits: command address and write data.
REQ-012 SHALL have o_ready, output, 1 bit: high when a command can be accepted.
REQ-013 SHALL have o_done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have o_err, output, 1 bit: marks a completion as timed out; valid only with o_done.
REQ-015 SHALL have o_rdata, output, DATA_WIDTH bits: read data.

Function
REQ-016 SHALL implement a one-hot FSM with three states: IDLE, SETUP and ACCESS.
REQ-017 SHALL register every output; no output may depend combinationally on any input.
REQ-018 SHALL drive o_ready=1 only in IDLE.
REQ-019 SHALL accept a command when i_req=1 and o_ready=1 at a clock edge, capture i_wr, i_addr and i_wdata into PWRITE, PADDR and PWDATA, and move to SETUP.
REQ-020 SHALL drive PSEL=1, PENABLE=0 in SETUP, then move to ACCESS unconditionally after one cycle.
REQ-021 SHALL drive PSEL=1, PENABLE=1 in ACCESS, holding PADDR, PWRITE and PWDATA stable.
REQ-022 SHALL complete the transfer when PREADY=1 is sampled in ACCESS:
- next cycle: o_done=1, o_err=0, state IDLE, PSEL=0, PENABLE=0;
- o_rdata <= PRDATA on reads; o_rdata unchanged on writes.
REQ-023 SHALL remain in ACCESS while PREADY=0 (wait states), with no upper bound unless APB_TIMEOUT_EN is defined.
REQ-024 SHALL ignore PREADY in IDLE and SETUP.
REQ-025 SHALL ignore i_req while o_ready=0; no queuing.
REQ-026 SHALL make the minimum spacing between acceptances 3 cycles: the IDLE cycle after o_done is mandatory.
REQ-027 SHALL hold PADDR, PWDATA and PWRITE at their last values in IDLE.
REQ-028 SHALL hold o_done and o_err high for exactly one cycle per completion.
REQ-029 SHALL hold o_rdata until the next read completion.
REQ-030 SHALL force an illegal FSM encoding to IDLE with PSEL=0 and PENABLE=0.

Reset
REQ-031 SHALL, while PRESET=1, immediately force:
- state IDLE;
- PSEL, PENABLE, PWRITE, o_done and o_err to 0;
- PADDR, PWDATA and o_rdata to all zeros;
- o_ready to 1;
- the timeout counter to 0.
REQ-032 SHALL abort a transfer interrupted by reset in SETUP or ACCESS with no o_done pulse.
REQ-033 SHALL accept a command at the first clock edge after PRESET deasserts.

Configuration
REQ-034 SHALL, with APB_TIMEOUT_EN defined:
- count consecutive ACCESS cycles with PREADY=0;
- when the count reaches TIMEOUT_CYCLES, go to IDLE next cycle with PSEL=0, PENABLE=0, o_done=1, o_err=1, o_rdata unchanged;
- clear the counter on entry to ACCESS.
REQ-035 SHALL, with APB_TIMEOUT_EN defined, give PREADY=1 priority over timeout when both occur in the same cycle (normal completion, o_err=0).
REQ-036 SHALL, with APB_TIMEOUT_EN undefined, omit the counter, wait indefinitely in ACCESS, and tie o_err to 0; the port list is identical in both builds.

Verification
REQ-037 SHALL cover a write with PREADY tied 1: accept i_addr=0x0004, i_wdata=0xA5A5 -> SETUP 1 cycle, ACCESS 1 cycle, o_done the next cycle, PWDATA=0xA5A5 throughout.
REQ-038 SHALL cover a read with 3 wait states: PRDATA=0x1234 presented when PREADY rises -> PENABLE high 4 cycles, o_rdata=0x1234 with o_done, o_err=0.
REQ-039 SHALL cover i_req held high continuously -> acceptances every 3 cycles with PREADY=1, PSEL low for exactly 1 cycle between transfers.
REQ-040 SHALL cover reset asserted during ACCESS -> PSEL=0, PENABLE=0, o_ready=1 immediately, no o_done pulse.
REQ-041 SHALL cover PREADY held 0 with APB_TIMEOUT_EN and TIMEOUT_CYCLES=16 -> o_done=1, o_err=1 after 16 ACCESS cycles; without the macro, no completion after 100 cycles.
REQ-042 SHALL cover PREADY rising in the same cycle the timeout count is reached -> o_err=0 and o_rdata updated.
